// File: rtl/map_table.sv
// Rename table mapping architectural registers to ROB tags, with two source lookups.
// Latency: lookups are combinational (zero cycles); state updates take effect at the next clock edge.
// Backpressure: none. Every dispatch, CDB and retire input is consumed in the cycle it is presented.
//
// Ports:
//   clock, reset                 rising-edge clock, asynchronous active-high reset
//   squash                       flush every mapping at the next edge; lookups read as zero this cycle
//   dispatch_*                   install dispatch_tag as the new producer of dispatch_dest_idx
//   cdb_valid, cdb_tag           mark the mappings that wait on cdb_tag as value-ready
//   retire_*                     clear a mapping, but only while it still names the retiring tag
//   rs1_*/rs2_* lookups          tag, renamed flag and ready flag for the two source registers
//   busy_count                   number of registers that are currently mapped
module map_table #(
    parameter int REG_LEN = 32,
    parameter int ROB_LEN = 8,
    localparam int REG_W = $clog2(REG_LEN),
    localparam int TAG_W = $clog2(ROB_LEN),
    localparam int CNT_W = REG_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             squash,
    input  logic             dispatch_valid,
    input  logic [REG_W-1:0] dispatch_dest_idx,
    input  logic [TAG_W-1:0] dispatch_tag,
    input  logic [REG_W-1:0] rs1_idx,
    input  logic [REG_W-1:0] rs2_idx,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic             retire_valid,
    input  logic [REG_W-1:0] retire_dest_idx,
    input  logic [TAG_W-1:0] retire_tag,
    output logic [TAG_W-1:0] rs1_tag,
    output logic [TAG_W-1:0] rs2_tag,
    output logic             rs1_tag_valid,
    output logic             rs2_tag_valid,
    output logic             rs1_ready,
    output logic             rs2_ready,
    output logic [CNT_W-1:0] busy_count
);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             valid;
        logic             ready;
    } lookup_t;

    logic [TAG_W-1:0] tag_q [REG_LEN];
    logic [REG_LEN-1:0] tag_valid_q;
    logic [REG_LEN-1:0] ready_q;

    logic dispatch_en;
    logic retire_clear;
    logic inc;
    logic dec;

    // Register 0 is hard-wired zero, so a dispatch to it never creates a mapping.
    assign dispatch_en = dispatch_valid && (dispatch_dest_idx != '0);

    // A retire counts only if the entry still names the retiring instruction.
    // Once a younger producer has been dispatched, the retire is stale and is dropped.
    assign retire_clear = retire_valid && (retire_dest_idx != '0)
                        && tag_valid_q[retire_dest_idx]
                        && (tag_q[retire_dest_idx] == retire_tag);

    assign inc = dispatch_en && !tag_valid_q[dispatch_dest_idx];
    assign dec = retire_clear && !(dispatch_en && (dispatch_dest_idx == retire_dest_idx));

    // Lookups read the registered state, so the current dispatch does not affect them.
    // CDB and retire bypasses let the reservation station see this cycle's completion or retirement.
    logic [REG_W-1:0] rs_idx [2];
    lookup_t          rs_res [2];

    assign rs_idx[0] = rs1_idx;
    assign rs_idx[1] = rs2_idx;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rs_res[p] = '0;
            if (!reset && !squash && (rs_idx[p] != '0) && tag_valid_q[rs_idx[p]]) begin
                rs_res[p].tag   = tag_q[rs_idx[p]];
                rs_res[p].valid = 1'b1;
                rs_res[p].ready = ready_q[rs_idx[p]]
                                | (cdb_valid && (tag_q[rs_idx[p]] == cdb_tag));
                if (retire_clear && (retire_dest_idx == rs_idx[p])) begin
                    // The value is being written to the register file this cycle.
                    rs_res[p].valid = 1'b0;
                    rs_res[p].ready = 1'b0;
                end
            end
        end
    end

    assign rs1_tag       = rs_res[0].tag;
    assign rs1_tag_valid = rs_res[0].valid;
    assign rs1_ready     = rs_res[0].ready;
    assign rs2_tag       = rs_res[1].tag;
    assign rs2_tag_valid = rs_res[1].valid;
    assign rs2_ready     = rs_res[1].ready;

    // Per-entry priority: squash > dispatch > retire > CDB.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < REG_LEN; r++) begin
                tag_q[r] <= '0;
            end
            tag_valid_q <= '0;
            ready_q     <= '0;
        end else if (squash) begin
            for (int r = 0; r < REG_LEN; r++) begin
                tag_q[r] <= '0;
            end
            tag_valid_q <= '0;
            ready_q     <= '0;
        end else begin
            for (int r = 0; r < REG_LEN; r++) begin
                if (dispatch_en && (dispatch_dest_idx == REG_W'(r))) begin
                    tag_q[r]       <= dispatch_tag;
                    tag_valid_q[r] <= 1'b1;
                    ready_q[r]     <= 1'b0;
                end else if (retire_clear && (retire_dest_idx == REG_W'(r))) begin
                    tag_valid_q[r] <= 1'b0;
                    ready_q[r]     <= 1'b0;
                end else if (cdb_valid && tag_valid_q[r] && (tag_q[r] == cdb_tag)) begin
                    ready_q[r] <= 1'b1;
                end
            end
        end
    end

    // Register 0 is never mapped, so the count cannot exceed REG_LEN-1.
    // inc and dec never fire on an inconsistent entry, so the count cannot wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_count <= '0;
        end else if (squash) begin
            busy_count <= '0;
        end else begin
            busy_count <= busy_count + CNT_W'(inc) - CNT_W'(dec);
        end
    end

endmodule

// File: tb/tb_map_table.sv
module tb_map_table;

    logic       clock;
    logic       reset;
    logic       squash;
    logic       dispatch_valid;
    logic [4:0] dispatch_dest_idx;
    logic [2:0] dispatch_tag;
    logic [4:0] rs1_idx;
    logic [4:0] rs2_idx;
    logic       cdb_valid;
    logic [2:0] cdb_tag;
    logic       retire_valid;
    logic [4:0] retire_dest_idx;
    logic [2:0] retire_tag;
    logic [2:0] rs1_tag;
    logic [2:0] rs2_tag;
    logic       rs1_tag_valid;
    logic       rs2_tag_valid;
    logic       rs1_ready;
    logic       rs2_ready;
    logic [5:0] busy_count;

    int n_cmp = 0;
    int n_err = 0;

    map_table #(.REG_LEN(32), .ROB_LEN(8)) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .dispatch_valid(dispatch_valid), .dispatch_dest_idx(dispatch_dest_idx),
        .dispatch_tag(dispatch_tag), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .retire_valid(retire_valid), .retire_dest_idx(retire_dest_idx),
        .retire_tag(retire_tag),
        .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
        .rs1_tag_valid(rs1_tag_valid), .rs2_tag_valid(rs2_tag_valid),
        .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
        .busy_count(busy_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change just after a falling edge, and outputs are sampled #1 later.
    task automatic idle();
        squash = 0; dispatch_valid = 0; dispatch_dest_idx = 0; dispatch_tag = 0;
        cdb_valid = 0; cdb_tag = 0; retire_valid = 0; retire_dest_idx = 0; retire_tag = 0;
    endtask

    task automatic tick();
        @(negedge clock);
        idle();
        #1;
    endtask

    task automatic do_reset();
        idle();
        rs1_idx = 0; rs2_idx = 0;
        reset = 1;
        @(negedge clock);
        reset = 0;
        #1;
    endtask

    task automatic dispatch(input logic [4:0] d, input logic [2:0] t);
        dispatch_valid = 1; dispatch_dest_idx = d; dispatch_tag = t;
        tick();
    endtask

    task automatic test_reset();
        reset = 1; idle(); rs1_idx = 0; rs2_idx = 0;
        #1;
        n_cmp++;
        if (busy_count !== 6'd0 || rs1_tag_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_initial: busy=%0d v=%b, required 0 0", busy_count, rs1_tag_valid);
        end
        @(negedge clock);
        reset = 0;
        #1;
        for (int r = 1; r <= 5; r++) dispatch(5'(r), 3'(r));
        rs1_idx = 2; rs2_idx = 5; cdb_valid = 1; cdb_tag = 2;
        #1;
        n_cmp++;
        if (busy_count !== 6'd5 || rs1_ready !== 1'b1 || rs2_tag !== 3'd5) begin
            n_err++;
            $display("FAIL reset_premap: busy=%0d rdy=%b tag=%0d, required 5 1 5",
                     busy_count, rs1_ready, rs2_tag);
        end
        // Raise reset while the clock is low. The clear must not wait for an edge.
        #1 reset = 1;
        #1;
        n_cmp++;
        if (busy_count !== 6'd0 || rs1_tag_valid !== 1'b0 || rs1_ready !== 1'b0 ||
            rs1_tag !== 3'd0 || rs2_tag_valid !== 1'b0 || rs2_tag !== 3'd0) begin
            n_err++;
            $display("FAIL reset_midrun: busy=%0d v1=%b r1=%b t1=%0d v2=%b t2=%0d, required all 0",
                     busy_count, rs1_tag_valid, rs1_ready, rs1_tag, rs2_tag_valid, rs2_tag);
        end
        idle();
        @(negedge clock);
        reset = 0;
        #1;
        n_cmp++;
        if (busy_count !== 6'd0 || rs2_tag_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: busy=%0d v2=%b, required 0 0", busy_count, rs2_tag_valid);
        end
    endtask

    task automatic test_dispatch_cdb();
        do_reset();
        dispatch(3, 2);
        rs1_idx = 3;
        #1;
        n_cmp++;
        if (rs1_tag !== 3'd2 || rs1_tag_valid !== 1'b1 || rs1_ready !== 1'b0 || busy_count !== 6'd1) begin
            n_err++;
            $display("FAIL dispatch_lookup: tag=%0d v=%b r=%b busy=%0d, required 2 1 0 1",
                     rs1_tag, rs1_tag_valid, rs1_ready, busy_count);
        end
        cdb_valid = 1; cdb_tag = 2;
        #1;
        n_cmp++;
        if (rs1_ready !== 1'b1) begin
            n_err++;
            $display("FAIL cdb_bypass: ready=%b, required 1", rs1_ready);
        end
        tick();
        n_cmp++;
        if (rs1_ready !== 1'b1 || rs1_tag_valid !== 1'b1) begin
            n_err++;
            $display("FAIL cdb_stored: ready=%b v=%b, required 1 1", rs1_ready, rs1_tag_valid);
        end
    endtask

    task automatic test_stale_retire();
        do_reset();
        dispatch(5, 1);
        dispatch(5, 4);
        retire_valid = 1; retire_dest_idx = 5; retire_tag = 1;
        tick();
        rs1_idx = 5;
        #1;
        n_cmp++;
        if (rs1_tag !== 3'd4 || rs1_tag_valid !== 1'b1 || busy_count !== 6'd1) begin
            n_err++;
            $display("FAIL stale_retire: tag=%0d v=%b busy=%0d, required 4 1 1",
                     rs1_tag, rs1_tag_valid, busy_count);
        end
        retire_valid = 1; retire_dest_idx = 5; retire_tag = 4;
        #1;
        n_cmp++;
        if (rs1_tag_valid !== 1'b0) begin
            n_err++;
            $display("FAIL retire_bypass: v=%b, required 0", rs1_tag_valid);
        end
        tick();
        n_cmp++;
        if (rs1_tag_valid !== 1'b0 || busy_count !== 6'd0) begin
            n_err++;
            $display("FAIL retire_clear: v=%b busy=%0d, required 0 0", rs1_tag_valid, busy_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        dispatch(7, 3);
        cdb_valid = 1; cdb_tag = 3;
        tick();
        rs1_idx = 7;
        dispatch_valid = 1; dispatch_dest_idx = 7; dispatch_tag = 6;
        #1;
        n_cmp++;
        if (rs1_tag !== 3'd3 || rs1_ready !== 1'b1 || rs1_tag_valid !== 1'b1) begin
            n_err++;
            $display("FAIL redispatch_old: tag=%0d r=%b v=%b, required 3 1 1",
                     rs1_tag, rs1_ready, rs1_tag_valid);
        end
        tick();
        n_cmp++;
        if (rs1_tag !== 3'd6 || rs1_ready !== 1'b0 || rs1_tag_valid !== 1'b1 || busy_count !== 6'd1) begin
            n_err++;
            $display("FAIL redispatch_new: tag=%0d r=%b v=%b busy=%0d, required 6 0 1 1",
                     rs1_tag, rs1_ready, rs1_tag_valid, busy_count);
        end
        // A CDB hit on the old tag in the same cycle as a dispatch must not mark the new mapping ready.
        dispatch_valid = 1; dispatch_dest_idx = 7; dispatch_tag = 2;
        cdb_valid = 1; cdb_tag = 6;
        tick();
        n_cmp++;
        if (rs1_tag !== 3'd2 || rs1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL dispatch_over_cdb: tag=%0d r=%b, required 2 0", rs1_tag, rs1_ready);
        end
    endtask

    task automatic test_retire_dispatch();
        do_reset();
        dispatch(9, 0);
        retire_valid = 1; retire_dest_idx = 9; retire_tag = 0;
        dispatch_valid = 1; dispatch_dest_idx = 9; dispatch_tag = 5;
        tick();
        rs1_idx = 9;
        #1;
        n_cmp++;
        if (rs1_tag !== 3'd5 || rs1_tag_valid !== 1'b1 || busy_count !== 6'd1) begin
            n_err++;
            $display("FAIL retire_vs_dispatch: tag=%0d v=%b busy=%0d, required 5 1 1",
                     rs1_tag, rs1_tag_valid, busy_count);
        end
        dispatch(0, 2);
        rs2_idx = 0;
        #1;
        n_cmp++;
        if (busy_count !== 6'd1 || rs2_tag !== 3'd0 || rs2_tag_valid !== 1'b0 || rs2_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reg0: busy=%0d tag=%0d v=%b r=%b, required 1 0 0 0",
                     busy_count, rs2_tag, rs2_tag_valid, rs2_ready);
        end
    endtask

    task automatic test_squash();
        do_reset();
        for (int r = 1; r <= 4; r++) dispatch(5'(r), 3'(r));
        rs1_idx = 2; rs2_idx = 6;
        #1;
        n_cmp++;
        if (busy_count !== 6'd4 || rs1_tag !== 3'd2) begin
            n_err++;
            $display("FAIL squash_premap: busy=%0d tag=%0d, required 4 2", busy_count, rs1_tag);
        end
        squash = 1;
        dispatch_valid = 1; dispatch_dest_idx = 6; dispatch_tag = 7;
        #1;
        n_cmp++;
        if (rs1_tag_valid !== 1'b0 || rs1_tag !== 3'd0 || rs1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL squash_lookup: v=%b tag=%0d r=%b, required 0 0 0",
                     rs1_tag_valid, rs1_tag, rs1_ready);
        end
        tick();
        n_cmp++;
        if (busy_count !== 6'd0 || rs1_tag_valid !== 1'b0 || rs2_tag_valid !== 1'b0) begin
            n_err++;
            $display("FAIL squash_after: busy=%0d v1=%b v2=%b, required 0 0 0",
                     busy_count, rs1_tag_valid, rs2_tag_valid);
        end
    endtask

    initial begin
        test_reset();
        test_dispatch_cdb();
        test_stale_retire();
        test_back_to_back();
        test_retire_dispatch();
        test_squash();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/map_table.md
Name: map_table

Overview:
- Architectural-register-to-ROB-tag rename table, directly downstream of the ROB.
- Dispatch installs the ROB tail tag on the destination register. CDB broadcasts mark mappings as value-ready. Retirement from the ROB head clears a mapping only if it is still current.
- Serves two source-operand lookups per cycle to the reservation station, with CDB bypass.

Parameters:
- REG_LEN, 32, number of architectural registers; register 0 is hard-wired zero.
- ROB_LEN, 8, ROB entries; TAG_W = $clog2(ROB_LEN).

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- squash  in  1  flush all mappings (branch mispredict).
- dispatch_valid  in  1  an instruction with a destination register is dispatching this cycle.
- dispatch_dest_idx  in  $clog2(REG_LEN)  destination register of the dispatching instruction.
- dispatch_tag  in  TAG_W  ROB tail index allocated to the dispatching instruction.
- rs1_idx, rs2_idx  in  $clog2(REG_LEN) each  source registers of the dispatching instruction.
- cdb_valid  in  1  CDB broadcast is valid.
- cdb_tag  in  TAG_W  ROB tag being broadcast.
- retire_valid  in  1  ROB head is retiring this cycle.
- retire_dest_idx  in  $clog2(REG_LEN)  destination register of the retiring entry.
- retire_tag  in  TAG_W  ROB index of the retiring entry.
- rs1_tag, rs2_tag  out  TAG_W each  ROB tag mapped to the source register.
- rs1_tag_valid, rs2_tag_valid  out  1 each  source is renamed (value lives in the ROB, not the register file).
- rs1_ready, rs2_ready  out  1 each  renamed value is already complete in the ROB.
- busy_count  out  $clog2(REG_LEN)+1  number of currently mapped registers.

Behaviour:
- State per register r: tag[r], tag_valid[r], ready[r]. Flops use asynchronous reset.
- Reset (asserted at any time, including mid-operation): every tag_valid, ready and tag is cleared to 0; busy_count=0. All outputs are 0 while reset is high.
- Register 0 is never mapped:
  - Dispatch with dest 0 is ignored.
  - Lookups of register 0 return tag_valid=0, ready=0, tag=0.
- Lookup (combinational, zero latency):
  - Returns the stored state for rsN_idx.
  - CDB bypass: if cdb_valid and the entry is tag_valid with tag==cdb_tag, rsN_ready=1 in the same cycle.
  - Retire bypass: if retire clears the entry this cycle, rsN_tag_valid=0 in the same cycle, and the value is read from the register file.
  - The same-cycle dispatch write is NOT visible to lookups: sources are read before their own instruction's destination is installed.
- Dispatch update at the clock edge: tag[d]<=dispatch_tag, tag_valid[d]<=1, ready[d]<=0, including when d was already mapped.
- CDB update: every entry with tag_valid and tag==cdb_tag gets ready<=1, unless that entry is overwritten by dispatch the same cycle.
- Retire update: if tag_valid[retire_dest_idx] and tag[retire_dest_idx]==retire_tag, clear tag_valid and ready. A stale retire (tag mismatch) leaves the entry unchanged.
- Same-cycle priority per entry: squash > dispatch > retire > CDB.
  - Dispatch and retire on the same register: the dispatch mapping survives.
- squash:
  - Next edge clears all tag_valid, ready and tag, and sets busy_count=0.
  - Dispatch, retire and CDB in the squash cycle are discarded.
  - Lookup outputs are forced to 0 during the squash cycle.
- busy_count, next value = current + inc - dec:
  - inc=1 when dispatch targets an unmapped nonzero register.
  - dec=1 when retire clears an entry that is not re-dispatched the same cycle.
  - Dispatch to an already-mapped register changes nothing.
  - Range is 0..REG_LEN-1; it never wraps.
- Tags are not checked for ROB occupancy; the ROB guarantees dispatch_tag uniqueness among live entries.

Test Plan:
- Reset mid-run with 5 registers mapped -> all outputs 0 and busy_count=0 immediately, without waiting for a clock edge.
- Dispatch r3 tag 2, next cycle rs1_idx=3 -> rs1_tag=2, rs1_tag_valid=1, rs1_ready=0, busy_count=1. Then cdb_valid tag 2 -> rs1_ready=1 in the same cycle and stays 1 after the edge.
- Dispatch r5 tag 1, then r5 tag 4, then retire r5 tag 1 -> r5 stays mapped to tag 4, busy_count=1. Retire r5 tag 4 -> tag_valid=0, busy_count=0.
- Same cycle: dispatch r7 tag 6 with rs1_idx=7 (r7 previously tag 3, ready) -> rs1 reports tag 3, ready=1. Next cycle reports tag 6, ready=0.
- Same cycle: retire r9 tag 0 and dispatch r9 tag 5 -> r9 mapped to tag 5, busy_count unchanged. Dispatch r0 -> ignored, lookup of r0 returns zeros.
- Map r1..r4, assert squash together with dispatch r6 -> lookups 0 that cycle. After the edge all unmapped, busy_count=0, r6 unmapped.
